// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: latency 1+MUL_STAGES (mul), 33 (div), 1 (div-by-zero/overflow).
// Holds the pipeline through stall until DONE; flush aborts MUL/DIV with no result pulse.
module muldiv_sequencer #(
  parameter int MUL_STAGES = 1,
  parameter int XLEN       = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            flush,
  output logic            stall,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [1:0]          r_func3_lo;
  logic [2*XLEN-1:0]   r_prod;
  logic [XLEN-1:0]     r_quo;
  logic [XLEN-1:0]     r_rem;
  logic [XLEN-1:0]     r_div;
  logic                r_qsign;
  logic                r_rsign;
  logic [XLEN-1:0]     r_result;
  logic                r_result_valid;

  logic                w_accept;
  logic                w_sdiv;
  logic                w_div_zero;
  logic                w_div_ovf;
  logic [XLEN-1:0]     w_op1_abs;
  logic [XLEN-1:0]     w_op2_abs;
  logic                w_a_signed;
  logic                w_b_signed;
  logic [2*XLEN-1:0]   w_mul_a;
  logic [2*XLEN-1:0]   w_mul_b;
  logic [2*XLEN-1:0]   w_prod;
  logic [XLEN:0]       w_shift_rem;
  logic [XLEN:0]       w_trial;
  logic [XLEN-1:0]     w_rem_next;
  logic [XLEN-1:0]     w_quo_next;
  logic [XLEN-1:0]     w_div_result;

  assign w_accept   = (r_state == S_IDLE) && start && !flush;
  assign w_sdiv     = !func3[0];
  assign w_div_zero = (op2 == '0);
  assign w_div_ovf  = w_sdiv && (op1 == INT_MIN) && (&op2);
  assign w_op1_abs  = (w_sdiv && op1[XLEN-1]) ? -op1 : op1;
  assign w_op2_abs  = (w_sdiv && op2[XLEN-1]) ? -op2 : op2;

  // MULH: both signed, MULHSU: only rs1 signed, MUL/MULHU: unsigned.
  assign w_a_signed = func3[1] ^ func3[0];
  assign w_b_signed = (func3[1:0] == 2'b01);
  assign w_mul_a    = {{XLEN{w_a_signed & op1[XLEN-1]}}, op1};
  assign w_mul_b    = {{XLEN{w_b_signed & op2[XLEN-1]}}, op2};
  assign w_prod     = w_mul_a * w_mul_b;

  // The shifted partial remainder can reach 2*divisor-1, hence the extra bit.
  assign w_shift_rem = {r_rem, r_quo[XLEN-1]};
  assign w_trial     = w_shift_rem - {1'b0, r_div};
  assign w_rem_next  = w_trial[XLEN] ? w_shift_rem[XLEN-1:0] : w_trial[XLEN-1:0];
  assign w_quo_next  = {r_quo[XLEN-2:0], ~w_trial[XLEN]};

  assign w_div_result = r_func3_lo[1] ? (r_rsign ? -w_rem_next : w_rem_next)
                                      : (r_qsign ? -w_quo_next : w_quo_next);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_func3_lo     <= '0;
      r_prod         <= '0;
      r_quo          <= '0;
      r_rem          <= '0;
      r_div          <= '0;
      r_qsign        <= 1'b0;
      r_rsign        <= 1'b0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_func3_lo <= func3[1:0];
            if (!func3[2]) begin
              // r_prod is the first multiply register; the MUL cycles give it time to settle.
              r_prod  <= w_prod;
              r_cnt   <= CW'(MUL_STAGES - 1);
              r_state <= S_MUL;
            end else if (w_div_zero) begin
              r_result       <= func3[1] ? op1 : '1;
              r_result_valid <= 1'b1;
              r_state        <= S_DONE;
            end else if (w_div_ovf) begin
              r_result       <= func3[1] ? '0 : INT_MIN;
              r_result_valid <= 1'b1;
              r_state        <= S_DONE;
            end else begin
              r_quo   <= w_op1_abs;
              r_div   <= w_op2_abs;
              r_rem   <= '0;
              r_qsign <= w_sdiv & (op1[XLEN-1] ^ op2[XLEN-1]);
              r_rsign <= w_sdiv & op1[XLEN-1];
              r_cnt   <= CW'(XLEN - 1);
              r_state <= S_DIV;
            end
          end
        end
        S_MUL: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else if (r_cnt == '0) begin
            r_result       <= (r_func3_lo == 2'b00) ? r_prod[XLEN-1:0] : r_prod[2*XLEN-1:XLEN];
            r_result_valid <= 1'b1;
            r_state        <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DIV: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            if (r_cnt == '0) begin
              r_result       <= w_div_result;
              r_result_valid <= 1'b1;
              r_state        <= S_DONE;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stall = rst_n && !flush &&
                 ((r_state == S_IDLE && start) || r_state == S_MUL || r_state == S_DIV);
  assign busy         = (r_state != S_IDLE);
  assign result_valid = r_result_valid;
  assign result       = r_result;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: driver pushes model results, monitor checks value and cycle.
module tb_muldiv_sequencer;

  localparam int S = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  func3;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        flush;
  logic        stall;
  logic        result_valid;
  logic [31:0] result;
  logic        busy;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc      = 0;
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   n_pulses = 0;

  muldiv_sequencer #(.MUL_STAGES(S), .XLEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .func3        (func3),
    .op1          (op1),
    .op2          (op2),
    .flush        (flush),
    .stall        (stall),
    .result_valid (result_valid),
    .result       (result),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: RISC-V M-extension semantics in plain arithmetic.
  function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    longint      p;
    logic [63:0] pu;
    int          sa;
    int          sb;
    sa = a;
    sb = b;
    case (f3)
      3'd0: return a * b;
      3'd1: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
      3'd2: begin p = longint'(sa) * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return 1 + S;
    if (b == 32'd0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic push_exp(input logic [31:0] res, input int at, input string name);
    exp_t e;
    e.res  = res;
    e.cyc  = at;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (i == 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_idle: busy=%b after 200 cycles, expected 0", busy);
    end
  endtask

  // Issue one op, push its expectation, scramble inputs after accept, and measure stall length.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input string name);
    int c;
    int n;
    int lat;
    wait_idle();
    @(posedge clk); #1;
    start = 1'b1;
    func3 = f3;
    op1   = a;
    op2   = b;
    c     = cyc;
    lat   = ref_lat(f3, a, b);
    push_exp(ref_res(f3, a, b), c + lat, name);
    n = 0;
    @(negedge clk);
    if (stall) n++;
    @(posedge clk); #1;
    start = 1'b0;
    func3 = 3'($urandom);
    op1   = $urandom;
    op2   = $urandom;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!stall) break;
      n++;
    end
    check({name, "_stall_len"}, 32'(n), 32'(lat));
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n === 1'b1 && result_valid === 1'b1) begin
      n_pulses++;
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pulse: result_valid=1 result=%h at cycle %0d, expected no pulse",
                 result, cyc);
      end else begin
        e = q.pop_front();
        check({e.name, "_val"}, result, e.res);
        check({e.name, "_cyc"}, 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int p0;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;

    rst_n = 1'b0;
    start = 1'b1;
    flush = 1'b0;
    func3 = 3'd0;
    op1   = 32'd5;
    op2   = 32'd3;
    repeat (3) @(negedge clk);
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_valid", {31'b0, result_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    start = 1'b0;
    rst_n = 1'b1;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, "mul");
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, "mulh");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu");
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, "mulhsu");
    run_op(3'd4, 32'hFFFF_FFEC, 32'd3, "div_neg");
    run_op(3'd6, 32'hFFFF_FFEC, 32'd3, "rem_neg");
    run_op(3'd5, 32'd100, 32'd7, "divu");
    run_op(3'd7, 32'd100, 32'd7, "remu");
    run_op(3'd4, 32'd5, 32'd0, "div_by0");
    run_op(3'd7, 32'd5, 32'd0, "remu_by0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");

    // flush while idle suppresses accept
    wait_idle();
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; func3 = 3'd5; op1 = 32'd9; op2 = 32'd2;
    @(negedge clk);
    check("idle_flush_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("idle_flush_busy", {31'b0, busy}, 32'd0);

    // flush at C+10 of a DIV, then DIVU 9/3 issued at C+11
    wait_idle();
    @(posedge clk); #1;
    start = 1'b1; func3 = 3'd4; op1 = 32'hFFFF_FFEC; op2 = 32'd3;
    c = cyc;
    do begin
      @(posedge clk); #1;
      start = 1'b0;
    end while (cyc < c + 10);
    flush = 1'b1;
    @(negedge clk);
    check("flush_stall_drop", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_cycle", 32'(cyc), 32'(c + 11));
    start = 1'b1; func3 = 3'd5; op1 = 32'd9; op2 = 32'd3;
    push_exp(ref_res(3'd5, 32'd9, 32'd3), c + 44, "post_flush_divu");
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();

    // back-to-back with start held: MUL then DIVU, exactly two pulses
    @(posedge clk); #1;
    p0 = n_pulses;
    start = 1'b1; func3 = 3'd0; op1 = 32'd6; op2 = 32'd7;
    c = cyc;
    push_exp(ref_res(3'd0, 32'd6, 32'd7), c + 1 + S, "b2b_mul");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (result_valid) break;
    end
    @(posedge clk); #1;
    func3 = 3'd5; op1 = 32'd50; op2 = 32'd5;
    c = cyc;
    push_exp(ref_res(3'd5, 32'd50, 32'd5), c + 33, "b2b_divu");
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (result_valid) break;
    end
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("b2b_pulses", 32'(n_pulses - p0), 32'd2);

    // async reset in the middle of a DIV
    wait_idle();
    @(posedge clk); #1;
    start = 1'b1; func3 = 3'd4; op1 = 32'd1000; op2 = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    start = 1'b1;
    rst_n = 1'b0;
    #1;
    check("midrst_stall", {31'b0, stall}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_valid", {31'b0, result_valid}, 32'd0);
    check("midrst_result", result, 32'd0);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: begin a = $urandom; b = 32'd0; end
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 1000)); b = 32'($urandom_range(1, 50)); end
        3: begin a = $urandom; b = 32'(-int'($urandom_range(1, 15))); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      run_op(f3, a, b, $sformatf("rnd%0d_f%0d", i, f3));
    end

    wait_idle();
    repeat (3) @(negedge clk);
    check("queue_empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle controller for the RV32M operations in the execute stage: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Latches operands from EX, sequences a pipelined multiply or a 32-iteration restoring divide, and stalls the pipeline until the result is ready.
- Sits beside the ALU. EX selects this block's result when the instruction is an M-op (opcode 0110011, func7 0000001).
- Handles RISC-V divide-by-zero and signed-overflow cases in a single cycle.

Parameters:
- MUL_STAGES, 1, number of registered multiply cycles between accept and DONE (legal range 1..4).
- XLEN, 32, operand width; only 32 is supported.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  EX holds a valid M-op (decoded upstream from opcode/func7)
- func3  input  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op1  input  32  rs1 value (forwarded)
- op2  input  32  rs2 value (forwarded)
- flush  input  1  pipeline flush of EX; aborts the operation in flight
- stall  output  1  hold IF/ID/EX; combinational
- result_valid  output  1  one-cycle pulse; result is valid this cycle
- result  output  32  M-op result
- busy  output  1  state is not IDLE

Behaviour:
- Clock and reset: one clock domain, clk. rst_n is asynchronous and active-low.
- Reset: state=IDLE, counter=0, all operand/quotient/remainder/product registers=0, result=0, result_valid=0, busy=0.
- stall is 0 while rst_n is low.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - On start && !flush: latch op1, op2, func3, then branch.
  - func3[2]=0: go to MUL, counter=MUL_STAGES-1.
  - func3[2]=1 and op2==0: go to DONE with special result.
    - DIV/DIVU quotient = 0xFFFFFFFF.
    - REM/REMU remainder = op1.
  - func3=100 or 110 with op1==0x80000000 and op2==0xFFFFFFFF: go to DONE.
    - DIV result 0x80000000; REM result 0.
  - Otherwise: go to DIV, counter=31.
    - Signed ops load |op1| and |op2|; record quotient sign (op1[31]^op2[31]) and remainder sign (op1[31]).
- MUL:
  - 64-bit product of sign- or zero-extended operands: MULH signed×signed, MULHSU signed×unsigned, MULHU and MUL unsigned×unsigned.
  - Decrement counter each cycle; go to DONE when counter==0.
  - MUL returns product[31:0]; all others return product[63:32].
- DIV:
  - One restoring step per cycle: shift {rem,quo} left by 1; trial subtract divisor from rem; if non-negative, commit and set quo[0]=1.
  - After the step at counter==0, go to DONE.
- DONE:
  - result_valid=1; result holds the selected, sign-corrected value.
  - Quotient is negated if its sign bit is set; remainder is negated if the dividend was negative.
  - Always return to IDLE next cycle. start is ignored in DONE, so the same instruction is never re-accepted.
- stall = (state==IDLE && start && !flush) || state==MUL || state==DIV. stall=0 in DONE, so the pipeline advances that cycle.
- Latency, counting the accept cycle as C:
  - MUL family: result_valid at C+1+MUL_STAGES; stall high for 1+MUL_STAGES cycles.
  - Normal divide: result_valid at C+33; stall high for 33 cycles.
  - Special cases: result_valid at C+1; stall high for 1 cycle.
- Back-to-back M-ops: the next op is accepted no earlier than the cycle after DONE.
- flush:
  - In MUL or DIV: go to IDLE next cycle, no result_valid pulse, stall drops combinationally that cycle.
  - In IDLE: suppresses accept.
  - In DONE: result_valid is still driven.
- Operands are latched at accept; op1/op2/func3 changes after accept have no effect.
- result holds its last value in IDLE. result_valid is high only in DONE.
- rst_n asserted mid-operation: immediate return to reset values.

Test Plan:
- MUL 7×(-3) (op2=0xFFFFFFFD), MUL_STAGES=1 -> stall high 2 cycles; result_valid at C+2; result=0xFFFFFFEB.
- MULH 0x80000000×0x80000000 -> result 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF×2 -> 0xFFFFFFFF.
- DIV -20/3 -> result_valid at C+33, result 0xFFFFFFFA. REM -20/3 -> 0xFFFFFFFE. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF at C+1. REMU 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM of the same operands -> 0. All at C+1.
- flush asserted at C+10 of a DIV -> busy=0 at C+11, no result_valid pulse. A new DIVU 9/3 issued at C+11 returns 3 at C+44.
- Back-to-back MUL then DIVU with start held high -> exactly two result_valid pulses and no re-accept in DONE. rst_n pulsed low mid-DIV -> stall, busy, result_valid are 0 immediately.
